// File: rtl/cmp_pkg.sv
// Shared types for the serial comparator: FSM state encoding and result encoding.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } result_t;

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-wide unsigned magnitude comparator.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator, MSB digit first, with early exit on the
// first differing digit. Supports unsigned and two's-complement ordering.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  localparam int NDIG = WIDTH / DIGIT,
  localparam int CW   = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles,
  output logic             fsm_state
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] TOP = IW'(NDIG - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_comparator: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da, db;
  logic             d_eq, d_gt, d_lt;
  result_t          res;
  logic             finish;

  // In signed mode the sign bit lives in the top digit; flipping it maps
  // two's-complement ordering onto unsigned ordering.
  always_comb begin
    da = a_q[idx*DIGIT +: DIGIT];
    db = b_q[idx*DIGIT +: DIGIT];
    if (sgn_q && (idx == TOP)) begin
      da[DIGIT-1] = ~da[DIGIT-1];
      db[DIGIT-1] = ~db[DIGIT-1];
    end
  end

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (da),
    .b  (db),
    .eq (d_eq),
    .gt (d_gt),
    .lt (d_lt)
  );

  always_comb begin
    res = LT;
    if (d_eq)      res = EQ;
    else if (d_gt) res = GT;
  end

  assign finish = (state == RUN) && ((res != EQ) || (idx == '0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= signed_mode;
            idx   <= TOP;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (finish) begin
            eq     <= (res == EQ);
            gt     <= (res == GT);
            lt     <= (res == LT);
            cycles <= cnt + CW'(1);
            done   <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign fsm_state = state;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a positive multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits compared per clock cycle; SHALL be 1 or greater.
REQ-003 Derived constant NDIG = WIDTH/DIGIT, the number of digits; CW = $clog2(NDIG)+1, the cycle-count width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 start  input  1  request a comparison; accepted only while idle.
REQ-007 signed_mode  input  1  1 = two's-complement comparison, 0 = unsigned; sampled with start.
REQ-008 a, b  input  WIDTH  operands; sampled with start.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 eq, gt, lt  output  1 each  result flags; one-hot after the first completion.
REQ-012 cycles  output  CW  number of digits examined by the last comparison.

Function
REQ-013 The block SHALL use the states IDLE and RUN.
REQ-014 IDLE with start=1: latch a, b and signed_mode; set digit index to NDIG-1; go to RUN; busy=1 from the next cycle.
REQ-015 IDLE with start=0: remain in IDLE.
REQ-016 RUN, each cycle: compare digit [idx*DIGIT +: DIGIT] of the latched operands MSB-first; increment the internal examined count.
REQ-017 On the top digit (idx=NDIG-1) with signed_mode=1: invert the MSB of both digits before comparing, so a negative operand orders below a positive one.
REQ-018 Digits differ: at that edge set gt or lt accordingly, set cycles = digits examined, pulse done for the next cycle, and return to IDLE (early termination).
REQ-019 Digits equal and idx=0: at that edge set eq=1, set cycles=NDIG, pulse done, and return to IDLE.
REQ-020 Digits equal and idx>0: decrement idx and stay in RUN.
REQ-021 Latency from the start-accept edge to done high is k cycles, where k is the 1-based position (from the MSB digit) of the first differing digit, or NDIG if the operands are equal; minimum 1, maximum NDIG.
REQ-022 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-023 start in the cycle done is high SHALL be accepted (back-to-back operation, no idle gap).
REQ-024 eq, gt, lt and cycles SHALL hold their last values until the next completion; they SHALL NOT change during RUN.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 at an edge: state=IDLE; busy, done, eq, gt, lt = 0; cycles = 0; latched operands and index cleared.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse is produced for it.
REQ-028 start asserted together with rst SHALL be ignored.

Structure
REQ-029 Shared package cmp_pkg SHALL hold the state enum (IDLE, RUN) and the result-encoding typedef (EQ, GT, LT).
REQ-030 Sub-module cmp_digit SHALL be a parametrised DIGIT-wide combinational magnitude comparator with eq/gt/lt outputs; it is instantiated once in the datapath.
REQ-031 An elaboration-time check SHALL flag a configuration in which WIDTH is not a multiple of DIGIT.

Verification (WIDTH=16, DIGIT=4)
REQ-032 a=16'h1234, b=16'h1234, unsigned, start -> done after 4 cycles; eq=1, gt=0, lt=0; cycles=4.
REQ-033 a=16'h8000, b=16'h0001: signed -> lt=1 with done after 1 cycle, cycles=1; unsigned -> gt=1 with done after 1 cycle.
REQ-034 a=16'h00A5, b=16'h00A3 -> gt=1, done after 4 cycles, cycles=4; start pulsed mid-run -> ignored, exactly one done.
REQ-035 Back-to-back: a second start in the done cycle with a=16'h0100, b=16'h0200 -> lt=1, done 2 cycles later, cycles=2.
REQ-036 rst asserted in the 2nd RUN cycle -> all outputs 0 the next cycle; no done pulse; a fresh start then completes normally.
